// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - four-digit multiplexed seven-segment scanner with frame-aligned shadow commit
// Optional leading-zero blanking is compiled in when LZ_BLANK_EN is defined.
module seg_scan #(
  parameter int CLK_DIV = 50000,
  parameter int GAP_CYC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp_in,
  output logic [3:0]  sel,
  output logic [7:0]  seg,
  output logic        frame
);

  localparam int TW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP_CYC - 1);

  localparam logic [0:0] ST_GAP  = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  logic [TW-1:0] tick_q, tick_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [0:0]    state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   shadow_q, shadow_d;
  logic [3:0]    sdp_q, sdp_d;
  logic [15:0]   pend_q, pend_d;
  logic [3:0]    pdp_q, pdp_d;
  logic          pflag_q, pflag_d;
  logic [3:0]    sel_q, sel_d;
  logic [7:0]    seg_q, seg_d;
  logic          frame_q, frame_d;
  logic          tick;
  logic [3:0]    nib;
  logic [6:0]    seg_lo;

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] r;
    case (n)
      4'h0: r = 7'h3F;  4'h1: r = 7'h06;  4'h2: r = 7'h5B;  4'h3: r = 7'h4F;
      4'h4: r = 7'h66;  4'h5: r = 7'h6D;  4'h6: r = 7'h7D;  4'h7: r = 7'h07;
      4'h8: r = 7'h7F;  4'h9: r = 7'h6F;  4'hA: r = 7'h77;  4'hB: r = 7'h7C;
      4'hC: r = 7'h39;  4'hD: r = 7'h5E;  4'hE: r = 7'h79;  default: r = 7'h71;
    endcase
    return r;
  endfunction

`ifdef LZ_BLANK_EN
  // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
  function automatic logic lz_blank(input logic [15:0] v, input logic [1:0] i);
    logic b;
    case (i)
      2'd1:    b = (v[15:4] == 12'h000);
      2'd2:    b = (v[15:8] == 8'h00);
      2'd3:    b = (v[15:12] == 4'h0);
      default: b = 1'b0;
    endcase
    return b;
  endfunction
`endif

  assign tick = (tick_q == TICK_LAST);

  // Next-state: tick divider, SHOW/GAP sequencing, pending capture and frame-aligned commit.
  always_comb begin
    tick_d   = tick ? '0 : tick_q + TW'(1);
    state_d  = state_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    pend_d   = pend_q;
    pdp_d    = pdp_q;
    pflag_d  = pflag_q;
    frame_d  = 1'b0;
    if (load) begin
      pend_d  = data;
      pdp_d   = dp_in;
      pflag_d = 1'b1;
    end
    if (state_q == ST_SHOW) begin
      if (tick) begin
        state_d = ST_GAP;
        gap_d   = '0;
      end
    end else begin
      if (gap_q == GAP_LAST) begin
        state_d = ST_SHOW;
        gap_d   = '0;
        idx_d   = idx_q + 2'd1;
        // Commit only on entry to digit 0 so a frame never mixes old and new data;
        // a load in this same cycle stays pending for the following frame.
        if (idx_d == 2'd0 && pflag_q) begin
          shadow_d = pend_q;
          sdp_d    = pdp_q;
          frame_d  = 1'b1;
          if (!load) pflag_d = 1'b0;
        end
      end else begin
        gap_d = gap_q + GW'(1);
      end
    end
  end

  // Output decode from next-state values so sel/seg are registered and change with the index.
  always_comb begin
    case (idx_d)
      2'd0:    nib = shadow_d[3:0];
      2'd1:    nib = shadow_d[7:4];
      2'd2:    nib = shadow_d[11:8];
      default: nib = shadow_d[15:12];
    endcase
    seg_lo = dec7(nib);
`ifdef LZ_BLANK_EN
    if (lz_blank(shadow_d, idx_d)) seg_lo = 7'h00;
`endif
    if (state_d == ST_SHOW) begin
      sel_d = 4'b0001 << idx_d;
      seg_d = {sdp_d[idx_d], seg_lo};
    end else begin
      sel_d = 4'b0000;
      seg_d = 8'h00;
    end
  end

  // State registers; reset aborts the scan and leaves the FSM in GAP before digit 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_q   <= '0;
      gap_q    <= '0;
      state_q  <= ST_GAP;
      idx_q    <= 2'd3;
      shadow_q <= 16'h0000;
      sdp_q    <= 4'b0000;
      pend_q   <= 16'h0000;
      pdp_q    <= 4'b0000;
      pflag_q  <= 1'b0;
      sel_q    <= 4'b0000;
      seg_q    <= 8'h00;
      frame_q  <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      gap_q    <= gap_d;
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      pend_q   <= pend_d;
      pdp_q    <= pdp_d;
      pflag_q  <= pflag_d;
      sel_q    <= sel_d;
      seg_q    <= seg_d;
      frame_q  <= frame_d;
    end
  end

  assign sel   = sel_q;
  assign seg   = seg_q;
  assign frame = frame_q;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - directed self-checking bench for seg_scan (CLK_DIV=8, GAP_CYC=2)
module tb_seg_scan;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp_in;
  logic [3:0]  sel;
  logic [7:0]  seg;
  logic        frame;

  int errors = 0;
  int checks = 0;

  seg_scan #(.CLK_DIV(8), .GAP_CYC(2)) dut (
    .clk(clk), .rst(rst), .load(load), .data(data), .dp_in(dp_in),
    .sel(sel), .seg(seg), .frame(frame)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to the first sample of a new frame (sel becomes 0001), bounded.
  task automatic wait_frame_start();
    logic [3:0] prev;
    logic found;
    prev  = sel;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (sel === 4'b0001 && prev !== 4'b0001) found = 1'b1;
      prev = sel;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL wait_frame_start: sel=%b never reached 0001", sel);
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp);
    load = 1'b1; data = d; dp_in = dp;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b0; data = 16'h0; dp_in = 4'h0;
    repeat (3) @(negedge clk);
    checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL reset_sel: got %b want 0000", sel); end
    checks++; if (seg !== 8'h00) begin errors++; $display("FAIL reset_seg: got %h want 00", seg); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b want 0", frame); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL release_gap: got %b want 0000", sel); end
    @(negedge clk);
    checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL release_first_sel: got %b want 0001", sel); end
    checks++; if (seg !== 8'h3F) begin errors++; $display("FAIL release_first_seg: got %h want 3F", seg); end
  endtask

  task automatic test_scan();
    logic [3:0] esel;
    logic [7:0] eseg;
    wait_frame_start();
    for (int k = 0; k < 32; k++) begin
      if ((k % 8) < 6) begin esel = 4'b0001 << (k / 8); eseg = 8'h3F; end
      else begin esel = 4'b0000; eseg = 8'h00; end
      checks++; if (sel !== esel) begin errors++; $display("FAIL scan_sel[%0d]: got %b want %b", k, sel, esel); end
      checks++; if (seg !== eseg) begin errors++; $display("FAIL scan_seg[%0d]: got %h want %h", k, seg, eseg); end
      checks++; if (frame !== 1'b0) begin errors++; $display("FAIL scan_frame[%0d]: got %b want 0", k, frame); end
      @(negedge clk);
    end
    checks++; if (sel !== 4'b0001) begin errors++; $display("FAIL scan_wrap: got %b want 0001", sel); end
  endtask

  task automatic test_load();
    wait_frame_start();
    repeat (2) @(negedge clk);
    do_load(16'h12AF, 4'b0100);
    repeat (5) @(negedge clk);
    checks++; if (sel !== 4'b0010 || seg !== 8'h3F) begin errors++; $display("FAIL load_unchanged: got %b/%h want 0010/3F", sel, seg); end
    wait_frame_start();
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL load_frame: got %b want 1", frame); end
    checks++; if (seg !== 8'h71) begin errors++; $display("FAIL load_d0: got %h want 71", seg); end
    @(negedge clk);
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL load_frame_pulse: got %b want 0", frame); end
    repeat (7) @(negedge clk);
    checks++; if (sel !== 4'b0010 || seg !== 8'h77) begin errors++; $display("FAIL load_d1: got %b/%h want 0010/77", sel, seg); end
    repeat (8) @(negedge clk);
    checks++; if (sel !== 4'b0100 || seg !== 8'hDB) begin errors++; $display("FAIL load_d2: got %b/%h want 0100/DB", sel, seg); end
    repeat (8) @(negedge clk);
    checks++; if (sel !== 4'b1000 || seg !== 8'h06) begin errors++; $display("FAIL load_d3: got %b/%h want 1000/06", sel, seg); end
  endtask

  task automatic test_double_load();
    wait_frame_start();
    repeat (2) @(negedge clk);
    do_load(16'h1111, 4'b0000);
    repeat (7) @(negedge clk);
    do_load(16'h2222, 4'b0000);
    wait_frame_start();
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL dbl_frame: got %b want 1", frame); end
    checks++; if (seg !== 8'h5B) begin errors++; $display("FAIL dbl_d0: got %h want 5B", seg); end
    repeat (8) @(negedge clk);
    checks++; if (seg !== 8'h5B) begin errors++; $display("FAIL dbl_d1: got %h want 5B", seg); end
    wait_frame_start();
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL dbl_single_pulse: got %b want 0", frame); end
    checks++; if (seg !== 8'h5B) begin errors++; $display("FAIL dbl_hold: got %h want 5B", seg); end
  endtask

  task automatic test_back_to_back();
    wait_frame_start();
    repeat (2) @(negedge clk);
    do_load(16'h0033, 4'b0000);
    repeat (28) @(negedge clk);
    checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL b2b_gap: got %b want 0000", sel); end
    load = 1'b1; data = 16'h0042; dp_in = 4'b0000;
    @(negedge clk);
    load = 1'b0;
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL b2b_frame1: got %b want 1", frame); end
    checks++; if (sel !== 4'b0001 || seg !== 8'h4F) begin errors++; $display("FAIL b2b_old_d0: got %b/%h want 0001/4F", sel, seg); end
    repeat (8) @(negedge clk);
    checks++; if (seg !== 8'h4F) begin errors++; $display("FAIL b2b_old_d1: got %h want 4F", seg); end
    wait_frame_start();
    checks++; if (frame !== 1'b1) begin errors++; $display("FAIL b2b_frame2: got %b want 1", frame); end
    checks++; if (seg !== 8'h5B) begin errors++; $display("FAIL b2b_new_d0: got %h want 5B", seg); end
    repeat (8) @(negedge clk);
    checks++; if (seg !== 8'h66) begin errors++; $display("FAIL b2b_new_d1: got %h want 66", seg); end
    repeat (8) @(negedge clk);
    checks++; if (seg !== 8'h3F) begin errors++; $display("FAIL b2b_new_d2: got %h want 3F", seg); end
  endtask

  task automatic test_reset_mid();
    wait_frame_start();
    repeat (18) @(negedge clk);
    checks++; if (sel !== 4'b0100) begin errors++; $display("FAIL mid_pre_sel: got %b want 0100", sel); end
    rst = 1'b0;
    #1;
    checks++; if (sel !== 4'b0000 || seg !== 8'h00) begin errors++; $display("FAIL mid_abort: got %b/%h want 0000/00", sel, seg); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sel !== 4'b0000) begin errors++; $display("FAIL mid_gap: got %b want 0000", sel); end
    @(negedge clk);
    checks++; if (sel !== 4'b0001 || seg !== 8'h3F) begin errors++; $display("FAIL mid_first: got %b/%h want 0001/3F", sel, seg); end
    checks++; if (frame !== 1'b0) begin errors++; $display("FAIL mid_frame: got %b want 0", frame); end
    repeat (8) @(negedge clk);
    checks++; if (sel !== 4'b0010 || seg !== 8'h3F) begin errors++; $display("FAIL mid_shadow: got %b/%h want 0010/3F", sel, seg); end
  endtask

`ifdef LZ_BLANK_EN
  task automatic test_lz_blank();
    do_load(16'h0007, 4'b0000);
    wait_frame_start();
    checks++; if (seg !== 8'h07) begin errors++; $display("FAIL lz7_d0: got %h want 07", seg); end
    for (int d = 1; d < 4; d++) begin
      repeat (8) @(negedge clk);
      checks++; if (seg !== 8'h00) begin errors++; $display("FAIL lz7_d%0d: got %h want 00", d, seg); end
    end
    do_load(16'h0000, 4'b0000);
    wait_frame_start();
    checks++; if (seg !== 8'h3F) begin errors++; $display("FAIL lz0_d0: got %h want 3F", seg); end
    for (int d = 1; d < 4; d++) begin
      repeat (8) @(negedge clk);
      checks++; if (seg !== 8'h00) begin errors++; $display("FAIL lz0_d%0d: got %h want 00", d, seg); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_double_load();
    test_back_to_back();
    test_reset_mid();
`ifdef LZ_BLANK_EN
    test_lz_blank();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 Parameter CLK_DIV, default 50000, clk cycles per digit dwell (scan tick period); legal range 4..2^20.
REQ-002 Parameter GAP_CYC, default 4, blanking cycles inserted before each digit switch; legal range 1..CLK_DIV-2.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserts immediately, releases on clk rising edge.
REQ-005 load  input  1  single-cycle strobe; captures data and dp_in into the pending register.
REQ-006 data  input  16  four nibbles; data[3:0] is digit 0 (rightmost), data[15:12] is digit 3.
REQ-007 dp_in  input  4  decimal-point enables; dp_in[n] belongs to digit n.
REQ-008 sel  output  4  one-hot digit enable, active-high, registered.
REQ-009 seg  output  8  segments, active-high, registered; seg[6:0] = g,f,e,d,c,b,a; seg[7] = dp.
REQ-010 frame  output  1  one-cycle pulse when the shadow register is committed.

Function
REQ-011 A tick counter SHALL count 0..CLK_DIV-1 and wrap to 0; a tick occurs in the cycle it equals CLK_DIV-1.
REQ-012 The FSM SHALL have states SHOW and GAP; reset state is GAP with digit index 3.
REQ-013 SHOW -> GAP on tick; in GAP, sel = 4'b0000 and seg = 8'h00 for exactly GAP_CYC cycles.
REQ-014 GAP -> SHOW after GAP_CYC cycles; digit index advances 0->1->2->3->0 (wrap 3->0), sel = 4'b0001 << index.
REQ-015 In SHOW, seg SHALL hold the decode of the shadow nibble for the current index plus its dp bit.
REQ-016 Decode (seg[6:0]): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-017 load SHALL write data/dp_in into the pending register and set a pending flag; a second load before commit overwrites it.
REQ-018 Commit (pending -> shadow, clear flag, frame pulse) SHALL occur only at the GAP -> SHOW transition into index 0, and only if pending is set.
REQ-019 load in the same cycle as a commit: the commit uses the old pending value; the new load stays pending for the next frame.
REQ-020 sel and seg SHALL never show a non-zero value simultaneously with a changing index (GAP guarantees zero overlap).
REQ-021 One full frame SHALL last 4*CLK_DIV cycles; each digit is lit CLK_DIV-GAP_CYC cycles.

Reset
REQ-022 On rst low: sel = 4'b0000, seg = 8'h00, frame = 0, tick counter = 0, gap counter = 0, index = 3, state = GAP.
REQ-023 On rst low: shadow = 16'h0000, shadow dp = 4'b0000, pending register and flag cleared.
REQ-024 Reset asserted mid-frame SHALL abort immediately; after release the first lit digit is index 0 with sel = 4'b0001 after GAP_CYC cycles.

Configuration
REQ-025 Macro LZ_BLANK_EN defined: digits 3..1 whose nibble and all higher nibbles are zero SHALL output seg[6:0] = 7'h00 (dp still honoured); digit 0 is always shown.
REQ-026 Macro LZ_BLANK_EN undefined: every digit is decoded per REQ-016; no blanking logic is present.

Verification (CLK_DIV=8, GAP_CYC=2)
REQ-027 Reset release, no load -> sel 0000 for 2 cycles, then 0001 with seg 3F; sequence 0001,0010,0100,1000 repeats every 32 cycles.
REQ-028 load with data=16'h12AF, dp_in=4'b0100 mid-frame -> unchanged until next index-0 entry; then frame=1 for one cycle, digits show 71,77,DB(5B|80),06.
REQ-029 Two loads (16'h1111 then 16'h2222) in one frame -> only 2222 displayed; one frame pulse.
REQ-030 load of 16'h0042 coincident with commit cycle -> old pending shown this frame, 0042 committed one frame later.
REQ-031 With LZ_BLANK_EN, data=16'h0007 -> digits 3,2,1 seg 00, digit 0 seg 07; data=16'h0000 -> only digit 0 shows 3F.
REQ-032 rst low during SHOW of index 2 -> sel/seg 0 same cycle; after release, index 0 lit after 2 cycles, shadow = 0.
